// File: rtl/pour_timer.sv
// pour_timer: timed-dispense engine shared by four pump channels.
// One seconds prescaler and one down-counter serve whichever channel won
// arbitration; only one channel pours at a time.
module pour_timer #(
    parameter int TICK_CYCLES = 50000000,
    parameter int SEC_W       = 4
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [3:0]       req,
    input  logic [SEC_W-1:0] pour_sec,
    output logic [3:0]       pour,
    output logic             busy,
    output logic [1:0]       active_ch,
    output logic [SEC_W-1:0] sec_left,
    output logic             done
);

    localparam int            PW      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_POUR, S_DONE} state_t;

    state_t           state, state_nx;
    logic [PW-1:0]    presc, presc_nx;
    logic [3:0]       pour_nx;
    logic [1:0]       ch_nx;
    logic [SEC_W-1:0] sec_nx;
    logic             done_nx;
    logic [1:0]       req_ch;
    logic             req_hold;

    // Served channel's request still asserted by the controller.
    assign req_hold = req[active_ch];
    assign busy     = (state == S_ARM) || (state == S_POUR);

    // Fixed-priority pick: lowest-index request wins.
    always_comb begin
        req_ch = 2'd0;
        if      (req[0]) req_ch = 2'd0;
        else if (req[1]) req_ch = 2'd1;
        else if (req[2]) req_ch = 2'd2;
        else if (req[3]) req_ch = 2'd3;
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nx = state;
        presc_nx = presc;
        pour_nx  = pour;
        ch_nx    = active_ch;
        sec_nx   = sec_left;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                pour_nx  = 4'b0000;
                sec_nx   = '0;
                presc_nx = '0;
                if (|req) begin
                    ch_nx    = req_ch;
                    sec_nx   = pour_sec;
                    state_nx = S_ARM;
                end
            end
            S_ARM: begin
                presc_nx = '0;
                if (!req_hold) begin
                    pour_nx  = 4'b0000;
                    sec_nx   = '0;
                    state_nx = S_IDLE;
                end else if (sec_left == '0) begin
                    // Zero-length shot: report completion without pumping.
                    pour_nx  = 4'b0000;
                    done_nx  = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    pour_nx  = 4'(4'b0001 << active_ch);
                    state_nx = S_POUR;
                end
            end
            S_POUR: begin
                if (!req_hold) begin
                    pour_nx  = 4'b0000;
                    sec_nx   = '0;
                    presc_nx = '0;
                    state_nx = S_IDLE;
                end else if (presc == PS_LAST) begin
                    presc_nx = '0;
                    if (sec_left == SEC_W'(1)) begin
                        pour_nx  = 4'b0000;
                        sec_nx   = '0;
                        done_nx  = 1'b1;
                        state_nx = S_DONE;
                    end else begin
                        sec_nx = sec_left - SEC_W'(1);
                    end
                end else begin
                    presc_nx = presc + PW'(1);
                end
            end
            S_DONE: begin
                pour_nx  = 4'b0000;
                sec_nx   = '0;
                presc_nx = '0;
                // Leave once the served channel lets go, so a still-high
                // request does not retrigger but another pending one can.
                if (!req_hold) state_nx = S_IDLE;
            end
            default: begin
                pour_nx  = 4'b0000;
                sec_nx   = '0;
                presc_nx = '0;
                state_nx = S_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state     <= S_IDLE;
            presc     <= '0;
            pour      <= 4'b0000;
            active_ch <= 2'd0;
            sec_left  <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            presc     <= presc_nx;
            pour      <= pour_nx;
            active_ch <= ch_nx;
            sec_left  <= sec_nx;
            done      <= done_nx;
        end
    end

endmodule

// File: tb/tb_pour_timer.sv
// tb_pour_timer: directed vectors with hand-computed expectations, TICK_CYCLES=10.
module tb_pour_timer;

    logic       clk = 1'b0;
    logic       RESET;
    logic [3:0] req;
    logic [3:0] pour_sec;
    logic [3:0] pour;
    logic       busy;
    logic [1:0] active_ch;
    logic [3:0] sec_left;
    logic       done;

    int n_chk = 0;
    int n_bad = 0;

    pour_timer #(.TICK_CYCLES(10), .SEC_W(4)) dut (
        .clk       (clk),
        .RESET     (RESET),
        .req       (req),
        .pour_sec  (pour_sec),
        .pour      (pour),
        .busy      (busy),
        .active_ch (active_ch),
        .sec_left  (sec_left),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int dn;
        RESET    = 1'b0;
        req      = 4'b0000;
        pour_sec = 4'd0;
        step(2);
        chk("rst_pour", int'(pour), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sec",  int'(sec_left), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ch",   int'(active_ch), 0);
        RESET = 1'b1;
        step(2);

        // Normal pour, channel 2, 3 s.
        req = 4'b0100; pour_sec = 4'd3;
        step();
        chk("np_arm_busy", int'(busy), 1);
        chk("np_arm_pour", int'(pour), 0);
        chk("np_ch",       int'(active_ch), 2);
        chk("np_sec_arm",  int'(sec_left), 3);
        step();
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (pour == 4'b0100) cnt++;
            if (k == 3)  pour_sec = 4'd7;
            if (k == 5)  chk("np_sec3", int'(sec_left), 3);
            if (k == 15) chk("np_sec2", int'(sec_left), 2);
            if (k == 25) chk("np_sec1", int'(sec_left), 1);
            step();
        end
        chk("np_len",      cnt, 30);
        chk("np_end_pour", int'(pour), 0);
        chk("np_end_sec",  int'(sec_left), 0);
        chk("np_done",     int'(done), 1);
        step();
        chk("np_done_1cy", int'(done), 0);
        chk("np_dn_busy",  int'(busy), 0);
        step(4);
        chk("np_no_rearm", int'(busy), 0);
        req = 4'b0000;
        step(2);
        chk("np_idle_busy", int'(busy), 0);
        chk("np_idle_pour", int'(pour), 0);

        // Arbitration and lock-out, 2 s.
        req = 4'b1010; pour_sec = 4'd2;
        step();
        chk("arb_ch", int'(active_ch), 1);
        step();
        chk("arb_pour", int'(pour), 4'b0010);
        step(5);
        req = 4'b1011;
        step(3);
        chk("lock_pour", int'(pour), 4'b0010);
        step(12);
        chk("lock_done",     int'(done), 1);
        chk("lock_end_pour", int'(pour), 0);
        req = 4'b1001;
        step();
        chk("lock_idle_busy", int'(busy), 0);
        step();
        chk("lock_arm_busy", int'(busy), 1);
        chk("lock_ch0",      int'(active_ch), 0);
        chk("lock_arm_pour", int'(pour), 0);
        step();
        chk("lock_ch0_pour", int'(pour), 4'b0001);
        req = 4'b0000;
        step();
        chk("lock_drop_pour", int'(pour), 0);
        chk("lock_drop_done", int'(done), 0);
        step();

        // Abort, channel 3, 5 s, drop after 12 pour cycles.
        req = 4'b1000; pour_sec = 4'd5;
        step(2);
        chk("ab_pour", int'(pour), 4'b1000);
        step(12);
        chk("ab_pour_mid", int'(pour), 4'b1000);
        chk("ab_sec_mid",  int'(sec_left), 4);
        req = 4'b0000;
        step();
        chk("ab_pour_off", int'(pour), 0);
        chk("ab_sec_off",  int'(sec_left), 0);
        chk("ab_busy",     int'(busy), 0);
        dn = int'(done);
        for (int k = 0; k < 5; k++) begin
            step();
            dn += int'(done);
        end
        chk("ab_no_done", dn, 0);
        chk("ab_ch_hold", int'(active_ch), 3);

        // Zero-length shot on channel 0.
        req = 4'b0001; pour_sec = 4'd0;
        step();
        chk("z_arm_busy", int'(busy), 1);
        chk("z_arm_done", int'(done), 0);
        step();
        chk("z_done", int'(done), 1);
        chk("z_pour", int'(pour), 0);
        dn = 0; cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            dn  += int'(done);
            cnt += int'(busy) + int'(pour != 4'b0000);
        end
        chk("z_done_once", dn, 0);
        chk("z_held",      cnt, 0);
        req = 4'b0000;
        step(2);
        chk("z_idle_busy", int'(busy), 0);

        // Asynchronous reset mid-pour.
        req = 4'b0001; pour_sec = 4'd3;
        step(2);
        step(15);
        chk("ar_pour_pre", int'(pour), 4'b0001);
        chk("ar_sec_pre",  int'(sec_left), 2);
        #2;
        RESET = 1'b0;
        #1;
        chk("ar_pour", int'(pour), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_sec",  int'(sec_left), 0);
        req = 4'b0000;
        step();
        RESET = 1'b1;
        step(2);
        chk("ar_idle_busy", int'(busy), 0);
        chk("ar_idle_pour", int'(pour), 0);
        req = 4'b0001;
        step();
        chk("ar_rearm", int'(busy), 1);
        req = 4'b0000;
        step(2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
